// File: rtl/lsu_ram_master.sv
// Load/store unit master for a single-port-style word RAM with registered read.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu_ram_master #(
    parameter int RAM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_wr_en_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o,
    output logic [31:0] ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i
);

    typedef enum logic [1:0] {IDLE, RDATA, WRITE, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_rsp_err;

    logic        w_accept, w_fn_bad, w_idx_bad, w_mis, w_err;
    logic [1:0]  w_off;
    logic [31:0] w_shift, w_load, w_mask, w_ins, w_merged;

    assign w_accept = (r_state == IDLE) && req_valid_i;

    always_comb begin
        w_fn_bad = 1'b0;
        if (req_we_i)
            w_fn_bad = req_funct3_i[2] || (req_funct3_i == 3'b011);
        else
            w_fn_bad = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                       (req_funct3_i == 3'b111);
    end

    assign w_idx_bad = {2'b00, req_addr_i[31:2]} >= 32'(RAM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_err = w_fn_bad || w_idx_bad || w_mis;

    // Lane offset: low bits a size cannot address are ignored (only reachable untrapped).
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_off = r_addr[1:0];
            2'b01:   w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_shift = ram_rd_data_i >> {w_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = ram_rd_data_i;
        endcase
    end

    assign w_mask   = ((r_funct3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {w_off, 3'b000};
    assign w_ins    = r_wdata << {w_off, 3'b000};
    assign w_merged = (ram_rd_data_i & ~w_mask) | (w_ins & w_mask);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    if (w_err)
                        w_next = RESP;
                    else if (req_we_i && (req_funct3_i == 3'b010))
                        w_next = WRITE;
                    else
                        w_next = RDATA;
                end
            end
            RDATA:   w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we_i;
                r_funct3 <= req_funct3_i;
                r_addr   <= req_addr_i;
                r_wdata  <= req_wdata_i;
            end
            // Sub-word stores reuse the data register for the merged word.
            if ((r_state == RDATA) && r_we)
                r_wdata <= w_merged;
            // Response fields change only on entry to RESP so they hold between responses.
            if ((w_next == RESP) && (r_state != RESP)) begin
                r_rsp_err <= (r_state == IDLE);
                r_rdata   <= ((r_state == RDATA) && !r_we) ? w_load : 32'h0;
            end
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = (r_state == RESP);
    assign rsp_rdata_o   = r_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign ram_wr_en_o   = (r_state == WRITE);
    assign ram_wr_addr_o = {r_addr[31:2], 2'b00};
    assign ram_wr_data_o = r_wdata;
    assign ram_rd_addr_o = w_accept ? {req_addr_i[31:2], 2'b00} : {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed table-driven bench for lsu_ram_master with a behavioural 32-word RAM.
module tb_lsu_ram_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;

    int n_vec = 0;
    int n_fail = 0;

    lsu_ram_master #(.RAM_WORDS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o), .ram_rd_addr_o(ram_rd_addr_o),
        .ram_rd_data_i(ram_rd_data_i)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:31];

    always @(posedge clk) begin
        if (ram_wr_en_o && (ram_wr_addr_o[31:7] == 25'h0))
            mem[ram_wr_addr_o[6:2]] <= ram_wr_data_o;
        ram_rd_data_i <= (ram_rd_addr_o[31:7] == 25'h0) ? mem[ram_rd_addr_o[6:2]] : 32'h0;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic        wr;
        logic [31:0] wdat;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and observe latency, write activity and response.
    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0;
        int wr_cnt = 0;
        int wr_cyc = 0;
        logic [31:0] wa = 0, wd = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, req_ready_o}, 32'h1);
        req_valid_i  = 1'b1;
        req_we_i     = v.we;
        req_funct3_i = v.f3;
        req_addr_i   = v.addr;
        req_wdata_i  = v.wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (ram_wr_en_o) begin
                wr_cnt++;
                wr_cyc = n;
                wa = ram_wr_addr_o;
                wd = ram_wr_data_o;
            end
            if (rsp_valid_o) begin
                lat = n;
                chk({tag, "_err"}, {31'h0, rsp_err_o}, {31'h0, v.err});
                chk({tag, "_rdata"}, rsp_rdata_o, v.rdata);
            end
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_wr_count"}, wr_cnt, v.wr ? 1 : 0);
        if (v.wr) begin
            chk({tag, "_wr_cycle"}, wr_cyc, v.lat - 1);
            chk({tag, "_wr_addr"}, wa, {v.addr[31:2], 2'b00});
            chk({tag, "_wr_data"}, wd, v.wdat);
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, {30'h0, rsp_valid_o, req_ready_o}, 32'h1);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;

        //           we    f3      addr          wdata          err   rdata          lat wr    wdat
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_0009, 32'h0,         1'b0, 32'hFFFF_FFBE, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_0009, 32'h0,         1'b0, 32'h0000_00BE, 2, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_000A, 32'h0,         1'b0, 32'hFFFF_DEAD, 2, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_000A, 32'h0,         1'b0, 32'h0000_DEAD, 2, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_000A, 32'h0000_0011, 1'b0, 32'h0,         3, 1'b1, 32'hDE11_BEEF};
        vecs[7]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,         1'b0, 32'hDE11_BEEF, 2, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_0004, 32'hCAFE_1234, 1'b0, 32'h0,         3, 1'b1, 32'h0000_1234};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0080, 32'h0,         1'b1, 32'h0,         1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0,         1, 1'b0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         1'b1, 32'h0,         1, 1'b0, 32'h0};
`else
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         1'b0, 32'h0000_1234, 2, 1'b0, 32'h0};
`endif
        vecs[13] = '{1'b1, 3'b010, 32'h0000_007C, 32'h8000_0000, 1'b0, 32'h0,         2, 1'b1, 32'h8000_0000};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_007F, 32'h0,         1'b0, 32'hFFFF_FF80, 2, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 3'b101, 32'h0000_007E, 32'h0,         1'b0, 32'h0000_8000, 2, 1'b0, 32'h0};

        repeat (2) @(negedge clk);
        chk("rst_wr_en", {31'h0, ram_wr_en_o}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after_release", {31'h0, req_ready_o}, 32'h1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an SB write: the write must vanish and no response follow.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0000_0008;
        req_wdata_i  = 32'h0000_0022;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_write", {31'h0, ram_wr_en_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en_drop", {31'h0, ram_wr_en_o}, 32'h0);
        chk("abort_rdata_cleared", rsp_rdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after_release", {31'h0, req_ready_o}, 32'h1);
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rsp_valid_o || ram_wr_en_o) seen++;
        end
        chk("abort_no_rsp_or_write", seen, 0);
        chk("abort_mem_untouched", mem[2], 32'hDE11_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ram_master.md
LSU_RAM_MASTER -- requirements
Module: lsu_ram_master

Interface
REQ-001 Parameter RAM_WORDS, default 32, number of 32-bit words in the attached RAM; word index >= RAM_WORDS is out of range.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  memory request present.
REQ-005 req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32I width/sign code: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 rsp_valid_o  output  1  one-cycle response pulse.
REQ-011 rsp_rdata_o  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err_o  output  1  request rejected; qualified by rsp_valid_o.
REQ-013 ram_wr_en_o, ram_wr_addr_o[31:0], ram_wr_data_o[31:0]  outputs  RAM word write port; address always word-aligned.
REQ-014 ram_rd_addr_o  output  32  RAM read address; RAM registers it, data returns next cycle.
REQ-015 ram_rd_data_i  input  32  RAM read data, valid the cycle after ram_rd_addr_o is sampled.

Function
REQ-016 FSM states IDLE, RDATA, WRITE, RESP; req_ready_o = 1 only in IDLE.
REQ-017 IDLE, handshake: latch we/funct3/addr/wdata; ram_rd_addr_o = {req_addr_i[31:2],2'b00} combinationally in that cycle.
REQ-018 Accept transitions: error -> RESP; SW -> WRITE; load, SB, SH -> RDATA.
REQ-019 Error if: funct3 invalid for direction (load 011/110/111, store 1xx/011), or word index >= RAM_WORDS, or misalignment per REQ-031.
REQ-020 RDATA, load: extract byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through; register into rsp_rdata_o; -> RESP.
REQ-021 RDATA, SB/SH: merge wdata[7:0] / wdata[15:0] into ram_rd_data_i at byte lane addr[1:0], other lanes unchanged; register merged word; -> WRITE.
REQ-022 WRITE: ram_wr_en_o = 1 for exactly this cycle, ram_wr_addr_o = {addr[31:2],2'b00}, ram_wr_data_o = wdata (SW) or merged word; -> RESP.
REQ-023 RESP: rsp_valid_o = 1 for exactly one cycle, rsp_err_o per REQ-019; -> IDLE.
REQ-024 Latency from handshake cycle C: error C+1; LW/LB/LH/LBU/LHU and SW C+2; SB/SH C+3; next accept earliest the cycle after RESP.
REQ-025 ram_wr_en_o = 0 outside WRITE; an erroring request never writes RAM.
REQ-026 ram_rd_addr_o outside the accept cycle holds the latched word address (RDATA data stays stable).
REQ-027 rsp_rdata_o, rsp_err_o hold value until next RESP.

Reset
REQ-028 rst_n low asynchronously forces IDLE, rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, ram_wr_en_o = 0, latched request = 0.
REQ-029 Reset during RDATA/WRITE aborts the access: no RAM write, no response issued afterwards.
REQ-030 req_ready_o = 1 in the first cycle after rst_n rises.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 is an error (REQ-019). Undefined: no misalignment error; offending low bits treated as 0 (half uses addr[1], word uses lane 0).

Verification
REQ-032 Reset, then SW addr 0x8 data 0xDEADBEEF -> ram_wr_en_o 1 cycle at C+1 addr 0x8, rsp_valid_o C+2 err 0.
REQ-033 Word 0x8 = 0xDEADBEEF; LB 0x9 -> rsp_rdata_o 0xFFFFFFBE at C+2; LBU 0x9 -> 0x000000BE; LH 0xA -> 0xFFFFDEAD.
REQ-034 Word 0x8 = 0xDEADBEEF; SB 0xA data 0x11 -> write at C+2 data 0xDE11BEEF, rsp at C+3; LW 0x8 then returns 0xDE11BEEF.
REQ-035 LW 0x80 (index 32, RAM_WORDS 32) -> rsp_valid_o C+1, rsp_err_o 1, no write; load funct3 011 likewise.
REQ-036 LW 0x6 with LSU_MISALIGN_TRAP_EN -> err at C+1; without -> reads word 0x4, rsp at C+2 err 0.
REQ-037 rst_n low during WRITE of an SB -> ram_wr_en_o drops immediately, no rsp_valid_o, req_ready_o 1 after release.
